bundler_bank_set: RTL and testbench



---
 rtl/bundler_pkg.sv | 28 ++
 rtl/bundler_counter_vec.sv | 54 +++++
 rtl/bundler_bank_set.sv | 92 +++++++++
 tb/tb_bundler_bank_set.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bundler_pkg.sv
// Shared types and constants for the multi-bank hypervector bundler.
// Latency: none; holds declarations only.
// Backpressure: not applicable.
package bundler_pkg;

   // Command encoding carried on op_i
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_CLR = 2'd2,
      OP_BIN = 2'd3
   } bundler_op_e;

   // Result FSM: idle (accepting commands) or holding a binarized result
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   // Largest positive value of a signed counter of width w
   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Most negative value of a signed counter of width w
   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/bundler_counter_vec.sv
// One bank of signed per-bit counters; step +/-1 per bit from hv_i, or clear.
// Latency: counters update at the edge where step_i/clr_i is high; clr_i wins.
// Backpressure: none; a step is taken every cycle step_i is high. Macro BUNDLER_BANK_SATURATE_EN selects saturate vs wrap.
module bundler_counter_vec
   import bundler_pkg::*;
#(
   parameter int HVDimension  = 512,
   parameter int CounterWidth = 8
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic                                      clr_i,
   input  logic                                      step_i,
   input  logic                                      down_i,
   input  logic [HVDimension-1:0]                    hv_i,
   output logic [HVDimension-1:0][CounterWidth-1:0]  counter_o
);

   localparam logic [CounterWidth-1:0] ONE = {{(CounterWidth-1){1'b0}}, 1'b1};
`ifdef BUNDLER_BANK_SATURATE_EN
   localparam logic [CounterWidth-1:0] CNT_MAX = CounterWidth'(sat_max(CounterWidth));
   localparam logic [CounterWidth-1:0] CNT_MIN = CounterWidth'(sat_min(CounterWidth));
`endif

   for (genvar i = 0; i < HVDimension; i++) begin : g_bit
      logic [CounterWidth-1:0] cnt_q;
      logic [CounterWidth-1:0] cnt_nxt;
      logic                    up;

      // Direction: a set bit counts up on ADD and down on SUB
      always_comb begin
         up      = hv_i[i] ^ down_i;
         cnt_nxt = up ? cnt_q + ONE : cnt_q - ONE;
`ifdef BUNDLER_BANK_SATURATE_EN
         if (up && (cnt_q == CNT_MAX)) cnt_nxt = cnt_q;
         if (!up && (cnt_q == CNT_MIN)) cnt_nxt = cnt_q;
`endif
      end

      // Counter register; clear overrides any step in the same cycle
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
         end else if (clr_i) begin
            cnt_q <= '0;
         end else if (step_i) begin
            cnt_q <= cnt_nxt;
         end
      end

      assign counter_o[i] = cnt_q;
   end

endmodule

// File: rtl/bundler_bank_set.sv
// NumBanks signed counter vectors updated by ADD/SUB/CLR; BIN returns a binarized bank.
// Latency: commands act at the accepting edge; BIN result is valid the following cycle.
// Backpressure: ready_o drops while a BIN result waits for bin_ready_i. Macro BUNDLER_BANK_SATURATE_EN selects saturate vs wrap.
module bundler_bank_set
   import bundler_pkg::*;
#(
   parameter int HVDimension  = 512,
   parameter int CounterWidth = 8,
   parameter int NumBanks     = 4,
   localparam int BankWidth   = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [HVDimension-1:0]                    hv_i,
   input  logic [1:0]                                op_i,
   input  logic [BankWidth-1:0]                      bank_i,
   input  logic                                      valid_i,
   output logic                                      ready_o,
   input  logic                                      clr_all_i,
   output logic [HVDimension-1:0]                    bin_hv_o,
   output logic                                      bin_valid_o,
   input  logic                                      bin_ready_i,
   input  logic [BankWidth-1:0]                      rd_bank_i,
   output logic [HVDimension-1:0][CounterWidth-1:0]  counter_o
);

   logic [HVDimension-1:0][CounterWidth-1:0] bank_cnt [NumBanks];
   logic [HVDimension-1:0][CounterWidth-1:0] sel_cnt;
   logic [HVDimension-1:0]                   bin_nxt;
   logic [0:0]                               state_q;
   bundler_op_e                              op;
   logic                                     accept;
   logic                                     is_step;

   assign op          = bundler_op_e'(op_i);
   assign ready_o     = (state_q == ST_IDLE);
   assign bin_valid_o = (state_q == ST_HOLD);
   assign accept      = valid_i && ready_o;
   assign is_step     = accept && ((op == OP_ADD) || (op == OP_SUB)) && !clr_all_i;

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
      logic hit;
      assign hit = (int'(bank_i) == b);

      bundler_counter_vec #(
         .HVDimension  (HVDimension),
         .CounterWidth (CounterWidth)
      ) u_vec (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .clr_i     (clr_all_i || (accept && (op == OP_CLR) && hit)),
         .step_i    (is_step && hit),
         .down_i    (op == OP_SUB),
         .hv_i      (hv_i),
         .counter_o (bank_cnt[b])
      );
   end

   // Bank decode for BIN source and read-back; out-of-range selects read as zero
   always_comb begin
      sel_cnt   = '0;
      counter_o = '0;
      for (int b = 0; b < NumBanks; b++) begin
         if (int'(bank_i) == b) sel_cnt = bank_cnt[b];
         if (int'(rd_bank_i) == b) counter_o = bank_cnt[b];
      end
   end

   // Binarize: strictly positive counters map to 1, zero and negative to 0
   always_comb begin
      bin_nxt = '0;
      for (int i = 0; i < HVDimension; i++) begin
         bin_nxt[i] = !sel_cnt[i][CounterWidth-1] && (|sel_cnt[i]);
      end
   end

   // Result FSM and result register; pre-clear values are captured on a same-cycle clr_all_i
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         bin_hv_o <= '0;
      end else if (state_q == ST_IDLE) begin
         if (accept && (op == OP_BIN)) begin
            bin_hv_o <= bin_nxt;
            state_q  <= ST_HOLD;
         end
      end else begin
         if (bin_ready_i) state_q <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_bundler_bank_set.sv
module tb_bundler_bank_set;
   import bundler_pkg::*;

   localparam int HV = 16;
   localparam int CW = 4;
   localparam int NB = 3;
   localparam int BW = 2;

   logic                       clk;
   logic                       rst_n;
   logic [HV-1:0]              hv_i;
   logic [1:0]                 op_i;
   logic [BW-1:0]              bank_i;
   logic                       valid_i;
   logic                       ready_o;
   logic                       clr_all_i;
   logic [HV-1:0]              bin_hv_o;
   logic                       bin_valid_o;
   logic                       bin_ready_i;
   logic [BW-1:0]              rd_bank_i;
   logic [HV-1:0][CW-1:0]      counter_o;

   int n_vec = 0;
   int n_bad = 0;

   bundler_bank_set #(
      .HVDimension  (HV),
      .CounterWidth (CW),
      .NumBanks     (NB)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .hv_i        (hv_i),
      .op_i        (op_i),
      .bank_i      (bank_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .clr_all_i   (clr_all_i),
      .bin_hv_o    (bin_hv_o),
      .bin_valid_o (bin_valid_o),
      .bin_ready_i (bin_ready_i),
      .rd_bank_i   (rd_bank_i),
      .counter_o   (counter_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  bank;
      logic [15:0] hv;
      logic [1:0]  rd;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl [12];

   // Expected counter vector: element i is hi where hv[i]=1, else lo
   function automatic logic [63:0] ev(input logic [15:0] hv, input logic [3:0] hi, input logic [3:0] lo);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i*4 +: 4] = hv[i] ? hi : lo;
      return r;
   endfunction

   function automatic logic [63:0] rep(input logic [3:0] v);
      return ev(16'hFFFF, v, v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cmd(input logic [1:0] op, input logic [1:0] bank, input logic [15:0] hv, input logic ca);
      op_i      = op;
      bank_i    = bank;
      hv_i      = hv;
      clr_all_i = ca;
      valid_i   = 1'b1;
      @(posedge clk);
      #1;
      valid_i   = 1'b0;
      clr_all_i = 1'b0;
   endtask

   task automatic consume();
      bin_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bin_ready_i = 1'b0;
   endtask

   task automatic rdchk(input logic [1:0] bank, input logic [63:0] exp, input string name);
      rd_bank_i = bank;
      #1;
      chk(name, counter_o, exp);
   endtask

   task automatic bin_chk(input logic [1:0] bank, input logic [15:0] exp, input string name);
      cmd(OP_BIN, bank, 16'h0000, 1'b0);
      chk({name, " valid"}, 64'(bin_valid_o), 64'd1);
      chk({name, " hv"}, 64'(bin_hv_o), 64'(exp));
      consume();
      chk({name, " ready"}, 64'(ready_o), 64'd1);
   endtask

   initial begin
      logic [3:0] sat_exp;

      tbl[0]  = '{OP_ADD, 2'd1, 16'hFFFF, 2'd1, rep(4'd1)};
      tbl[1]  = '{OP_ADD, 2'd1, 16'hFFFF, 2'd1, rep(4'd2)};
      tbl[2]  = '{OP_ADD, 2'd1, 16'hFFFF, 2'd1, rep(4'd3)};
      tbl[3]  = '{OP_ADD, 2'd1, 16'h0000, 2'd1, rep(4'd2)};
      tbl[4]  = '{OP_ADD, 2'd2, 16'hAAAA, 2'd2, ev(16'hAAAA, 4'h1, 4'hF)};
      tbl[5]  = '{OP_SUB, 2'd2, 16'hAAAA, 2'd0, rep(4'd0)};
      tbl[6]  = '{OP_ADD, 2'd0, 16'h00FF, 2'd2, rep(4'd0)};
      tbl[7]  = '{OP_ADD, 2'd3, 16'hFFFF, 2'd0, ev(16'h00FF, 4'h1, 4'hF)};
      tbl[8]  = '{OP_ADD, 2'd3, 16'hFFFF, 2'd3, rep(4'd0)};
      tbl[9]  = '{OP_CLR, 2'd0, 16'hFFFF, 2'd0, rep(4'd0)};
      tbl[10] = '{OP_SUB, 2'd0, 16'h0F0F, 2'd0, ev(16'h0F0F, 4'hF, 4'h1)};
      tbl[11] = '{OP_CLR, 2'd0, 16'h0000, 2'd1, rep(4'd2)};

      rst_n       = 1'b0;
      hv_i        = '0;
      op_i        = '0;
      bank_i      = '0;
      valid_i     = 1'b0;
      clr_all_i   = 1'b0;
      bin_ready_i = 1'b0;
      rd_bank_i   = '0;

      // Reset state
      #3;
      chk("rst valid", 64'(bin_valid_o), 64'd0);
      chk("rst ready", 64'(ready_o), 64'd1);
      #9;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst hv", 64'(bin_hv_o), 64'd0);
      rdchk(2'd0, rep(4'd0), "rst cnt0");

      // BIN of a fresh bank
      bin_chk(2'd0, 16'h0000, "bin0 fresh");

      // Table of single-cycle commands
      for (int k = 0; k < 12; k++) begin
         cmd(tbl[k].op, tbl[k].bank, tbl[k].hv, 1'b0);
         chk($sformatf("vec%0d ready", k), 64'(ready_o), 64'd1);
         rdchk(tbl[k].rd, tbl[k].exp, $sformatf("vec%0d cnt", k));
      end

      // Binarization: positive, tie, out-of-range, mixed
      bin_chk(2'd1, 16'hFFFF, "bin1 pos");
      bin_chk(2'd2, 16'h0000, "bin2 tie");
      bin_chk(2'd3, 16'h0000, "bin3 oor");
      cmd(OP_ADD, 2'd0, 16'h1234, 1'b0);
      bin_chk(2'd0, 16'h1234, "bin0 mixed");
      cmd(OP_CLR, 2'd0, 16'h0000, 1'b0);

      // Stalled result: output stable, commands refused
      cmd(OP_BIN, 2'd1, 16'h0000, 1'b0);
      op_i    = OP_ADD;
      bank_i  = 2'd1;
      hv_i    = 16'hFFFF;
      valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d valid", c), 64'(bin_valid_o), 64'd1);
         chk($sformatf("stall%0d hv", c), 64'(bin_hv_o), 64'hFFFF);
         chk($sformatf("stall%0d ready", c), 64'(ready_o), 64'd0);
      end
      valid_i = 1'b0;
      rdchk(2'd1, rep(4'd2), "stall cnt1");
      consume();
      chk("stall release ready", 64'(ready_o), 64'd1);
      chk("stall release valid", 64'(bin_valid_o), 64'd0);

      // BIN with same-cycle clr_all_i sees pre-clear values
      cmd(OP_BIN, 2'd1, 16'h0000, 1'b1);
      chk("binclr hv", 64'(bin_hv_o), 64'hFFFF);
      rdchk(2'd1, rep(4'd0), "binclr cnt1");
      consume();

      // Limit behaviour on a 4-bit counter
      for (int n = 1; n <= 9; n++) begin
         cmd(OP_ADD, 2'd0, 16'hFFFF, 1'b0);
`ifdef BUNDLER_BANK_SATURATE_EN
         sat_exp = 4'd7;
`else
         sat_exp = 4'(n);
`endif
         if (n >= 7) rdchk(2'd0, rep(sat_exp), $sformatf("limit add%0d", n));
      end

      // clr_all_i overrides a same-cycle ADD
      cmd(OP_ADD, 2'd2, 16'hFFFF, 1'b0);
      rdchk(2'd2, rep(4'd1), "pre clrall cnt2");
      cmd(OP_ADD, 2'd2, 16'hFFFF, 1'b1);
      rdchk(2'd0, rep(4'd0), "clrall cnt0");
      rdchk(2'd1, rep(4'd0), "clrall cnt1");
      rdchk(2'd2, rep(4'd0), "clrall cnt2");

      // Reset during HOLD drops the result asynchronously
      cmd(OP_ADD, 2'd1, 16'hFFFF, 1'b0);
      cmd(OP_BIN, 2'd1, 16'h0000, 1'b0);
      chk("hold valid", 64'(bin_valid_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst valid", 64'(bin_valid_o), 64'd0);
      chk("async rst hv", 64'(bin_hv_o), 64'd0);
      #5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post rst ready", 64'(ready_o), 64'd1);
      rdchk(2'd1, rep(4'd0), "post rst cnt1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
